class_window_gen: RTL and testbench

- Streaming 3x3 RGB window generator; the producer side of the classification block's 27-tap input interface.
- Accepts a raster-order RGB pixel stream, holds two previous lines, and emits one complete 3x3 window per interior pixel.
- Tap numbering matches the classifier: 1 2 3 / 4 5 6 / 7 8 9, row-major; tap 1 = (cx-1, cy-1).
- Sits between the frame input and the classifier, so window outputs connect tap-for-tap.

---
 rtl/class_pkg.sv | 32 +++
 rtl/line_delay.sv | 35 +++
 rtl/class_window_gen.sv | 139 +++++++++++++
 tb/tb_class_window_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/class_pkg.sv
// rtl/class_pkg.sv - shared defaults, tap indices, FSM states and result codes for the classifier path
package class_pkg;

  localparam int PIX_BIT_DEF = 8;
  localparam int IMG_W_DEF   = 640;
  localparam int IMG_H_DEF   = 480;

  // Window tap numbering, row-major, tap 1 is the top-left neighbour
  localparam int TAP_TL = 1;
  localparam int TAP_TC = 2;
  localparam int TAP_TR = 3;
  localparam int TAP_ML = 4;
  localparam int TAP_MC = 5;
  localparam int TAP_MR = 6;
  localparam int TAP_BL = 7;
  localparam int TAP_BC = 8;
  localparam int TAP_BR = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } win_state_t;

  typedef enum logic [2:0] {
    CLS_RES_0 = 3'd0,
    CLS_RES_1 = 3'd1,
    CLS_RES_2 = 3'd2,
    CLS_RES_3 = 3'd3,
    CLS_RES_4 = 3'd4
  } cls_result_t;

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - enable-gated DEPTH-sample delay line with zero-latency read
module line_delay #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // The slot about to be overwritten holds the sample written DEPTH enables ago
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/class_window_gen.sv
// rtl/class_window_gen.sv - streaming 3x3 RGB window generator feeding the classifier taps
module class_window_gen
  import class_pkg::*;
#(
  parameter int PIX_BIT = PIX_BIT_DEF,
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int XW      = $clog2(IMG_W),
  parameter int YW      = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [PIX_BIT-1:0]   in_r,
  input  logic [PIX_BIT-1:0]   in_g,
  input  logic [PIX_BIT-1:0]   in_b,
  output logic                 win_valid,
  output logic [9*PIX_BIT-1:0] win_r,
  output logic [9*PIX_BIT-1:0] win_g,
  output logic [9*PIX_BIT-1:0] win_b,
  output logic [XW-1:0]        win_cx,
  output logic [YW-1:0]        win_cy,
  output logic                 win_eof,
  output logic                 frame_err
);

  localparam int PW = 3 * PIX_BIT;

  win_state_t       state;
  logic [XW-1:0]    col;
  logic [YW-1:0]    row;

  logic             accept;
  logic [XW-1:0]    pix_x;
  logic [YW-1:0]    pix_y;
  logic             last_pix;
  logic [PW-1:0]    pix;
  logic [PW-1:0]    above1;
  logic [PW-1:0]    above2;
  logic [3*PW-1:0]  cur_col;
  logic [3*PW-1:0]  prev1_col;
  logic [3*PW-1:0]  prev2_col;
  logic [PW-1:0]    tap [1:9];

  // An sof pixel always lands at (0,0), whether it opens a frame or aborts one
  assign accept   = in_valid && ((state == ACTIVE) || in_sof);
  assign pix_x    = in_sof ? '0 : col;
  assign pix_y    = in_sof ? '0 : row;
  assign last_pix = (pix_x == XW'(IMG_W - 1)) && (pix_y == YW'(IMG_H - 1));
  assign pix      = {in_r, in_g, in_b};
  assign cur_col  = {above2, above1, pix};

  line_delay #(.DEPTH(IMG_W), .WIDTH(PW)) u_line0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (pix),
    .dout (above1)
  );

  line_delay #(.DEPTH(IMG_W), .WIDTH(PW)) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (above1),
    .dout (above2)
  );

  // Columns are packed {top, middle, bottom}; prev2 is the left window column
  always_comb begin
    tap[TAP_TL] = prev2_col[3*PW-1 -: PW];
    tap[TAP_TC] = prev1_col[3*PW-1 -: PW];
    tap[TAP_TR] = cur_col[3*PW-1 -: PW];
    tap[TAP_ML] = prev2_col[2*PW-1 -: PW];
    tap[TAP_MC] = prev1_col[2*PW-1 -: PW];
    tap[TAP_MR] = cur_col[2*PW-1 -: PW];
    tap[TAP_BL] = prev2_col[PW-1:0];
    tap[TAP_BC] = prev1_col[PW-1:0];
    tap[TAP_BR] = cur_col[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prev1_col <= cur_col;
      prev2_col <= prev1_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_r     <= '0;
      win_g     <= '0;
      win_b     <= '0;
      win_cx    <= '0;
      win_cy    <= '0;
      win_eof   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
      frame_err <= 1'b0;
      if (accept) begin
        frame_err <= in_sof && (state == ACTIVE);
        // Column/row gating alone keeps stale line history out of the window
        if ((pix_x >= XW'(2)) && (pix_y >= YW'(2))) begin
          win_valid <= 1'b1;
          win_cx    <= pix_x - 1'b1;
          win_cy    <= pix_y - 1'b1;
          win_eof   <= last_pix;
          for (int k = 1; k <= 9; k++) begin
            win_r[(k-1)*PIX_BIT +: PIX_BIT] <= tap[k][3*PIX_BIT-1 -: PIX_BIT];
            win_g[(k-1)*PIX_BIT +: PIX_BIT] <= tap[k][2*PIX_BIT-1 -: PIX_BIT];
            win_b[(k-1)*PIX_BIT +: PIX_BIT] <= tap[k][PIX_BIT-1:0];
          end
        end
        if (last_pix) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end else begin
          state <= ACTIVE;
          if (pix_x == XW'(IMG_W - 1)) begin
            col <= '0;
            row <= pix_y + 1'b1;
          end else begin
            col <= pix_x + 1'b1;
            row <= pix_y;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_class_window_gen.sv
// tb/tb_class_window_gen.sv - randomized and directed self-checking bench for class_window_gen
module tb_class_window_gen;

  localparam int PB = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_sof;
  logic [PB-1:0]   in_r, in_g, in_b;
  logic            win_valid;
  logic [9*PB-1:0] win_r, win_g, win_b;
  logic [XW-1:0]   win_cx;
  logic [YW-1:0]   win_cy;
  logic            win_eof;
  logic            frame_err;

  class_window_gen #(.PIX_BIT(PB), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .win_valid (win_valid),
    .win_r     (win_r),
    .win_g     (win_g),
    .win_b     (win_b),
    .win_cx    (win_cx),
    .win_cy    (win_cy),
    .win_eof   (win_eof),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a picture of the current frame plus a raster position
  bit              m_active;
  int              m_x, m_y;
  logic [23:0]     img [H][W];
  logic            exp_valid, exp_err, exp_eof;
  logic [9*PB-1:0] exp_r, exp_g, exp_b;
  logic [XW-1:0]   exp_cx;
  logic [YW-1:0]   exp_cy;

  task automatic model_step();
    logic [23:0] p;
    if (rst) begin
      m_active = 0; m_x = 0; m_y = 0;
      exp_valid = 0; exp_err = 0; exp_eof = 0;
      exp_r = '0; exp_g = '0; exp_b = '0; exp_cx = '0; exp_cy = '0;
      return;
    end
    exp_valid = 0; exp_err = 0; exp_eof = 0;
    if (in_valid && (m_active || in_sof)) begin
      if (in_sof) begin
        exp_err = m_active;
        m_x = 0; m_y = 0; m_active = 1;
      end
      img[m_y][m_x] = {in_r, in_g, in_b};
      if (m_x >= 2 && m_y >= 2) begin
        exp_valid = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            p = img[m_y-2+i][m_x-2+j];
            exp_r[(i*3+j)*PB +: PB] = p[23:16];
            exp_g[(i*3+j)*PB +: PB] = p[15:8];
            exp_b[(i*3+j)*PB +: PB] = p[7:0];
          end
        exp_cx  = XW'(m_x - 1);
        exp_cy  = YW'(m_y - 1);
        exp_eof = (m_x == W-1) && (m_y == H-1);
      end
      m_x++;
      if (m_x == W) begin
        m_x = 0; m_y++;
        if (m_y == H) begin m_y = 0; m_active = 0; end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input logic [23:0] px);
    rst = r; in_valid = v; in_sof = s;
    {in_r, in_g, in_b} = px;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [23:0] pix_of(input int kind, input int x, input int y);
    logic [7:0] a, b;
    case (kind)
      0: begin a = 8'(10*y + x); return {a, a, a}; end
      1: begin a = 8'(50 + 10*y + x); return {a, a, a}; end
      default: begin a = 8'(x); b = 8'(255 - x); return {a, 8'(y), b}; end
    endcase
  endfunction

  task automatic send_range(input int kind, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      cyc(0, 1, i == 0, pix_of(kind, i % W, i / W));
      repeat (gap) cyc(0, 0, 0, 24'h0);
    end
  endtask

  // Per-cycle compare against the model, plus event bookkeeping
  bit              started = 0;
  bit              color_mode = 0;
  int              n_win, n_eof, n_err;
  int              win_q[$];
  logic [9*PB-1:0] first_r;
  logic [7:0]      diff;

  task automatic clr_counts();
    n_win = 0; n_eof = 0; n_err = 0; win_q.delete();
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("win_valid", win_valid, exp_valid);
      chk("frame_err", frame_err, exp_err);
      chk("win_eof", win_eof, exp_eof);
      chk("win_r", win_r, exp_r);
      chk("win_g", win_g, exp_g);
      chk("win_b", win_b, exp_b);
      chk("win_cx", win_cx, exp_cx);
      chk("win_cy", win_cy, exp_cy);
      if (frame_err) n_err++;
      if (win_valid) begin
        if (n_win == 0) first_r = win_r;
        n_win++;
        win_q.push_back(int'(win_cx) * 16 + int'(win_cy));
        if (win_eof) n_eof++;
        if (color_mode) begin
          diff = win_r[31:24] - win_r[47:40];
          chk("color_tap4_minus_tap6", diff, 8'hFE);
        end
      end
    end
  end

  task automatic check_order(input string name);
    int exp_q[$];
    exp_q = '{1*16+1, 2*16+1, 3*16+1, 1*16+2, 2*16+2, 3*16+2};
    chk({name, "_count"}, n_win, 6);
    chk({name, "_eof_count"}, n_eof, 1);
    for (int i = 0; i < 6 && i < win_q.size(); i++)
      chk({name, "_centre"}, win_q[i], exp_q[i]);
  endtask

  initial begin
    logic [9*PB-1:0] first_lit;
    rst = 1; in_valid = 0; in_sof = 0; in_r = 0; in_g = 0; in_b = 0;
    clr_counts();
    cyc(1, 0, 0, 24'h0);
    started = 1;
    cyc(1, 1, 1, 24'hABCDEF);
    cyc(0, 0, 0, 24'h0);
    chk("reset_win_valid", win_valid, 0);
    chk("reset_win_r", win_r, 0);
    chk("reset_frame_err", frame_err, 0);

    // Continuous frame, value 10*row+col
    clr_counts();
    send_range(0, 0, W*H-1, 0);
    cyc(0, 0, 0, 24'h0);
    check_order("cont");
    first_lit = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};
    chk("cont_first_taps", first_r, first_lit);
    chk("cont_no_err", n_err, 0);

    // Back-to-back frames: sof right after the final pixel is not an error
    clr_counts();
    send_range(0, 0, W*H-1, 0);
    send_range(0, 0, W*H-1, 3);
    chk("b2b_windows", n_win, 12);
    chk("b2b_no_err", n_err, 0);

    // Gapped frame
    clr_counts();
    send_range(0, 0, W*H-1, 3);
    cyc(0, 0, 0, 24'h0);
    check_order("gap");
    chk("gap_first_taps", first_r, first_lit);

    // sof injected at (3,2)
    clr_counts();
    send_range(0, 0, 12, 0);
    send_range(1, 0, W*H-1, 0);
    cyc(0, 0, 0, 24'h0);
    chk("sof_inj_err", n_err, 1);
    chk("sof_inj_windows", n_win, 7);

    // sof on the final pixel position
    clr_counts();
    send_range(0, 0, W*H-2, 0);
    send_range(1, 0, W*H-1, 1);
    cyc(0, 0, 0, 24'h0);
    chk("sof_last_err", n_err, 1);
    chk("sof_last_windows", n_win, 11);

    // Reset mid row 3, then stray pixels, then a clean frame
    clr_counts();
    send_range(0, 0, 17, 0);
    cyc(1, 0, 0, 24'h0);
    chk("midrst_valid", win_valid, 0);
    chk("midrst_r", win_r, 0);
    chk("midrst_cx", win_cx, 0);
    clr_counts();
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, pix_of(0, i % W, 0));
    chk("idle_no_win", n_win, 0);
    chk("idle_no_err", n_err, 0);
    send_range(0, 0, W*H-1, 0);
    cyc(0, 0, 0, 24'h0);
    check_order("post_rst");

    // Colour plane separation
    clr_counts();
    color_mode = 1;
    send_range(2, 0, W*H-1, 1);
    cyc(0, 0, 0, 24'h0);
    color_mode = 0;
    chk("color_windows", n_win, 6);

    // Random traffic: values, gaps, stray and aborting sofs, rare resets
    for (int c = 0; c < 3000; c++) begin
      bit v, s, r;
      v = ($urandom_range(0, 3) != 0);
      s = v && (m_active ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 3) == 0));
      r = ($urandom_range(0, 400) == 0);
      cyc(r, v, s, 24'($urandom));
    end
    cyc(0, 0, 0, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
